// File: rtl/edge_count_scheduler_if.sv
// Bus between the edge-count scheduler and its controller / readout logic.
// Carries the start/abort controls, sweep configuration, channel signals and result fields.
interface edge_count_scheduler_if #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2,
  parameter int CNT_W  = 8,
  parameter int WIN_W  = 16
) ();
  logic              in_start;
  logic              in_abort;
  logic [NUM_CH-1:0] in_ch_enable;
  logic [WIN_W-1:0]  in_window;
  logic [NUM_CH-1:0] in_signal;
  logic              out_busy;
  logic              out_valid;
  logic [CH_W-1:0]   out_ch;
  logic [CNT_W-1:0]  out_count;
  logic              out_overflow;
  logic              out_done;

  modport master (
    output in_start, in_abort, in_ch_enable, in_window, in_signal,
    input  out_busy, out_valid, out_ch, out_count, out_overflow, out_done
  );

  modport slave (
    input  in_start, in_abort, in_ch_enable, in_window, in_signal,
    output out_busy, out_valid, out_ch, out_count, out_overflow, out_done
  );
endinterface

// File: rtl/edge_count_scheduler.sv
// Shares one rising-edge counter across NUM_CH inputs: sweeps enabled channels in
// ascending order, counting edges over a programmed window and reporting each result.
module edge_count_scheduler #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2,
  parameter int CNT_W  = 8,
  parameter int WIN_W  = 16
) (
  input logic                   in_clock,
  input logic                   in_reset,
  edge_count_scheduler_if.slave bus
);
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_COUNT  = 2'd2;
  localparam logic [1:0] ST_REPORT = 2'd3;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [WIN_W-1:0] WIN_ONE = {{(WIN_W-1){1'b0}}, 1'b1};

  // Lowest enabled channel at index >= first; MSB of the result flags "found".
  function automatic logic [CH_W:0] find_ch(input logic [NUM_CH-1:0] mask, input int first);
    logic [CH_W:0] res;
    res = {(CH_W+1){1'b0}};
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && (i >= first)) begin
        res = {1'b1, CH_W'(i)};
      end
    end
    return res;
  endfunction

  logic [1:0]        state_q, state_d;
  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [WIN_W-1:0]  win_q, win_d;
  logic [WIN_W-1:0]  timer_q, timer_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              prev_q, prev_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic [CH_W-1:0]   och_q, och_d;
  logic [CNT_W-1:0]  ocnt_q, ocnt_d;
  logic              oovf_q, oovf_d;

  logic              sel_s, edge_s, ovf_upd_s;
  logic [CNT_W-1:0]  cnt_upd_s;
  logic [CH_W:0]     first_s, next_s;

  assign sel_s   = bus.in_signal[ptr_q];
  assign edge_s  = sel_s & ~prev_q;
  assign first_s = find_ch(bus.in_ch_enable, 0);
  assign next_s  = find_ch(mask_q, int'(ptr_q) + 1);

  // Saturating edge counter update; an edge at full scale only raises overflow.
  always_comb begin
    cnt_upd_s = cnt_q;
    ovf_upd_s = ovf_q;
    if (edge_s) begin
      if (cnt_q == CNT_MAX) begin
        ovf_upd_s = 1'b1;
      end else begin
        cnt_upd_s = cnt_q + CNT_ONE;
      end
    end else begin
      cnt_upd_s = cnt_q;
    end
  end

  // Sweep FSM; result outputs are staged on the last COUNT cycle so they are registered.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    mask_d  = mask_q;
    win_d   = win_q;
    timer_d = timer_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    prev_d  = prev_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    och_d   = och_q;
    ocnt_d  = ocnt_q;
    oovf_d  = oovf_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_start && !bus.in_abort) begin
          mask_d = bus.in_ch_enable;
          win_d  = bus.in_window;
          if ((bus.in_ch_enable == {NUM_CH{1'b0}}) || (bus.in_window == {WIN_W{1'b0}})) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_SETTLE;
            ptr_d   = first_s[CH_W-1:0];
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (bus.in_abort) begin
          state_d = ST_IDLE;
        end else begin
          prev_d  = sel_s;
          cnt_d   = {CNT_W{1'b0}};
          ovf_d   = 1'b0;
          timer_d = win_q;
          state_d = ST_COUNT;
        end
      end
      ST_COUNT: begin
        if (bus.in_abort) begin
          state_d = ST_IDLE;
        end else begin
          prev_d  = sel_s;
          cnt_d   = cnt_upd_s;
          ovf_d   = ovf_upd_s;
          timer_d = timer_q - WIN_ONE;
          if (timer_q == WIN_ONE) begin
            state_d = ST_REPORT;
            valid_d = 1'b1;
            done_d  = ~next_s[CH_W];
            och_d   = ptr_q;
            ocnt_d  = cnt_upd_s;
            oovf_d  = ovf_upd_s;
          end else begin
            state_d = ST_COUNT;
          end
        end
      end
      ST_REPORT: begin
        if (bus.in_abort || !next_s[CH_W]) begin
          state_d = ST_IDLE;
        end else begin
          ptr_d   = next_s[CH_W-1:0];
          state_d = ST_SETTLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= {CH_W{1'b0}};
      mask_q  <= {NUM_CH{1'b0}};
      win_q   <= {WIN_W{1'b0}};
      timer_q <= {WIN_W{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      ovf_q   <= 1'b0;
      prev_q  <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      och_q   <= {CH_W{1'b0}};
      ocnt_q  <= {CNT_W{1'b0}};
      oovf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      mask_q  <= mask_d;
      win_q   <= win_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      prev_q  <= prev_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      och_q   <= och_d;
      ocnt_q  <= ocnt_d;
      oovf_q  <= oovf_d;
    end
  end

  assign bus.out_busy     = busy_q;
  assign bus.out_valid    = valid_q;
  assign bus.out_done     = done_q;
  assign bus.out_ch       = och_q;
  assign bus.out_count    = ocnt_q;
  assign bus.out_overflow = oovf_q;
endmodule
